// File: rtl/scramble_pkg.sv
// -----------------------------------------------------------------------------
// scramble_pkg
// Definitions shared by the SDRAM arbiter and its request slots:
//   - arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - SDRAM_AW    : default SDRAM byte-address width
//   - SDRAM_DW    : default SDRAM data width
// -----------------------------------------------------------------------------
package scramble_pkg;

    localparam int SDRAM_AW = 25;
    localparam int SDRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a full slot
        ISSUE = 2'd1,   // command strobe is high this cycle
        WAIT  = 2'd2    // waiting for mem_ready, watchdog running
    } arb_state_t;

endpackage

// File: rtl/arb_slot.sv
// -----------------------------------------------------------------------------
// arb_slot
// One-entry request buffer for a single requester of the SDRAM arbiter.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   req           : one-cycle request pulse
//   addr, data    : request payload, sampled with req
//   grant         : arbiter takes the buffered request this cycle
//   full          : slot holds a request
//   addr_q,data_q : buffered payload (data_q is tied to 0 when HAS_DATA=0)
//   overrun       : req arrived while the slot was full and not being granted;
//                   the request is dropped (single-cycle, unregistered flag)
//
// A grant frees the slot on the same edge, so a req arriving in the grant
// cycle is captured rather than flagged as an overrun.
// -----------------------------------------------------------------------------
module arb_slot
    import scramble_pkg::*;
#(
    parameter int AW       = SDRAM_AW,
    parameter int DW       = SDRAM_DW,
    parameter bit HAS_DATA = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          grant,
    output logic          full,
    output logic [AW-1:0] addr_q,
    output logic [DW-1:0] data_q,
    output logic          overrun
);

    logic take;

    // Capture when empty, or when the current entry is leaving this cycle.
    assign take    = req && (!full || grant);
    assign overrun = req && full && !grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full   <= 1'b0;
            addr_q <= '0;
        end else if (take) begin
            full   <= 1'b1;
            addr_q <= addr;
        end else if (grant) begin
            full   <= 1'b0;
        end
    end

    generate
        if (HAS_DATA) begin : g_data
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_q <= '0;
                end else if (take) begin
                    data_q <= data;
                end
            end
        end else begin : g_no_data
            // Read-only requester: no payload register.
            logic unused_data;
            assign unused_data = ^data;
            assign data_q      = '0;
        end
    endgenerate

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller port between the asset loader (writes) and the
// VFD renderer (reads). Each requester has a one-entry slot; the loader has
// fixed priority except when a VFD read has waited through STARVE loader
// grants. A watchdog aborts transfers the controller never completes, and an
// aborted read still returns (all-ones) data so the VFD cannot stall.
//
// Parameters:
//   AW, DW   : address / data width
//   TIMEOUT  : cycles spent in WAIT before abort (>= 2)
//   STARVE   : loader grants, with a VFD read pending, before the VFD wins
//
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   ld_req, ld_addr, ld_data     : loader write request (pulse + payload)
//   ld_busy                      : loader slot full
//   vf_req, vf_addr              : VFD read request (pulse + address)
//   vf_data, vf_valid            : read data, held; one-cycle completion pulse
//   mem_addr, mem_din            : command address / write data to controller
//   mem_rd, mem_we               : one-cycle command strobes
//   mem_dout, mem_ready          : controller read data / completion pulse
//   timeout_err                  : sticky, a transfer was aborted
//   overrun_err                  : sticky, a request was dropped (slot full)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdram_arbiter
    import scramble_pkg::*;
#(
    parameter int AW      = SDRAM_AW,
    parameter int DW      = SDRAM_DW,
    parameter int TIMEOUT = 64,
    parameter int STARVE  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_busy,
    input  logic          vf_req,
    input  logic [AW-1:0] vf_addr,
    output logic [DW-1:0] vf_data,
    output logic          vf_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_rd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ready,
    output logic          timeout_err,
    output logic          overrun_err
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(STARVE + 1);

    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE);

    arb_state_t     state;
    logic           is_read;    // transfer in flight is a VFD read
    logic [WW-1:0]  wdog;
    logic [SW-1:0]  starve;     // loader grants taken while a VFD read waited

    logic           ld_full, vf_full;
    logic [AW-1:0]  ld_addr_q, vf_addr_q;
    logic [DW-1:0]  ld_data_q, vf_unused_data;
    logic           ld_ovr, vf_ovr;
    logic           vf_starved, grant_ld, grant_vf;

    // ---------------------------------------------------------------- slots
    arb_slot #(.AW(AW), .DW(DW), .HAS_DATA(1'b1)) u_ld_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (ld_req),
        .addr    (ld_addr),
        .data    (ld_data),
        .grant   (grant_ld),
        .full    (ld_full),
        .addr_q  (ld_addr_q),
        .data_q  (ld_data_q),
        .overrun (ld_ovr)
    );

    arb_slot #(.AW(AW), .DW(DW), .HAS_DATA(1'b0)) u_vf_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (vf_req),
        .addr    (vf_addr),
        .data    ('0),
        .grant   (grant_vf),
        .full    (vf_full),
        .addr_q  (vf_addr_q),
        .data_q  (vf_unused_data),
        .overrun (vf_ovr)
    );

    // ---------------------------------------------------------------- grant
    // Loader wins by default; a VFD read that has sat through STARVE loader
    // grants takes the next slot.
    assign vf_starved = vf_full && (starve >= STARVE_LIM);
    assign grant_ld   = (state == IDLE) && ld_full && !vf_starved;
    assign grant_vf   = (state == IDLE) && vf_full && !grant_ld;

    // Slot-full flag is itself a register.
    assign ld_busy = ld_full;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            is_read     <= 1'b0;
            wdog        <= '0;
            starve      <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_rd      <= 1'b0;
            mem_we      <= 1'b0;
            vf_data     <= '0;
            vf_valid    <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Strobes and the completion pulse default low every cycle.
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
            vf_valid <= 1'b0;

            if (ld_ovr || vf_ovr) begin
                overrun_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_ld) begin
                        mem_addr <= ld_addr_q;
                        mem_din  <= ld_data_q;
                        mem_we   <= 1'b1;
                        is_read  <= 1'b0;
                        state    <= ISSUE;
                        if (vf_full) begin
                            starve <= starve + 1'b1;
                        end
                    end else if (grant_vf) begin
                        mem_addr <= vf_addr_q;
                        mem_rd   <= 1'b1;
                        is_read  <= 1'b1;
                        starve   <= '0;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Strobe is high during this state; mem_ready is ignored.
                    wdog  <= '0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (mem_ready) begin
                        if (is_read) begin
                            vf_data  <= mem_dout;
                            vf_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (wdog == WD_LAST) begin
                        // Abort; reads still complete so the VFD never hangs.
                        timeout_err <= 1'b1;
                        if (is_read) begin
                            vf_data  <= '1;
                            vf_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int AW      = 25;
    localparam int DW      = 8;
    localparam int TIMEOUT = 64;
    localparam int STARVE  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_busy;
    logic          vf_req;
    logic [AW-1:0] vf_addr;
    logic [DW-1:0] vf_data;
    logic          vf_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_rd;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;
    logic          timeout_err;
    logic          overrun_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // controller model controls
    int resp_lat    = 1;    // 0 = never answer
    bit resp_rand   = 1'b0;
    bit stray_ready = 1'b0;
    logic [7:0] memm [logic [AW-1:0]];

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        int            cyc;
    } strobe_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } vv_t;

    strobe_t slog[$];
    vv_t     vlog[$];

    sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_busy     (ld_busy),
        .vf_req      (vf_req),
        .vf_addr     (vf_addr),
        .vf_data     (vf_data),
        .vf_valid    (vf_valid),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout),
        .mem_ready   (mem_ready),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SDRAM controller model + observers (strobe log, vf_valid log).
    initial begin : responder
        bit         pend;
        int         cnt;
        logic [7:0] rd_val;
        pend      = 1'b0;
        cnt       = 0;
        rd_val    = '0;
        mem_ready = 1'b0;
        mem_dout  = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (stray_ready) begin
                    mem_ready   = 1'b1;
                    mem_dout    = 8'h77;
                    stray_ready = 1'b0;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend      = 1'b0;
                        mem_ready = 1'b1;
                        mem_dout  = rd_val;
                    end
                end
                if (mem_we || mem_rd) begin
                    slog.push_back('{mem_we, mem_addr, mem_din, cyc});
                    if (mem_we) begin
                        memm[mem_addr] = mem_din;
                        rd_val = 8'h00;
                    end else begin
                        rd_val = memm.exists(mem_addr) ? memm[mem_addr] : (mem_addr[7:0] ^ 8'h5A);
                    end
                    if (resp_rand) begin
                        pend = 1'b1;
                        cnt  = $urandom_range(1, 6);
                    end else if (resp_lat > 0) begin
                        pend = 1'b1;
                        cnt  = resp_lat;
                    end
                end
                if (vf_valid) vlog.push_back('{vf_data, cyc});
            end
        end
    end

    task automatic log_clear();
        slog.delete();
        vlog.delete();
    endtask

    function automatic int count_reads();
        int n = 0;
        foreach (slog[k]) if (!slog[k].we) n++;
        return n;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ld_req  = 1'b0;
        vf_req  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [46:0] outs;
        repeat (3) @(negedge clk);
        outs = {mem_rd, mem_we, vf_valid, ld_busy, timeout_err, overrun_err, mem_addr, mem_din, vf_data};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_we, ld_busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 000", {mem_rd, mem_we, ld_busy});
        end
    endtask

    task automatic test_single_write();
        int c, busy_n;
        log_clear();
        resp_lat = 1;
        busy_n   = 0;
        @(negedge clk);
        c = cyc;
        ld_req = 1'b1; ld_addr = 25'h000100; ld_data = 8'hA5;
        @(negedge clk);
        ld_req = 1'b0;
        if (ld_busy) busy_n++;
        repeat (8) begin
            @(negedge clk);
            if (ld_busy) busy_n++;
        end
        checks++;
        if (slog.size() != 1) begin
            errors++;
            $display("FAIL wr_strobe_count: got %0d expected 1", slog.size());
        end else begin
            checks++;
            if ({slog[0].we, slog[0].addr, slog[0].din} !== {1'b1, 25'h000100, 8'hA5}) begin
                errors++;
                $display("FAIL wr_cmd: got we=%0b addr=%h din=%h expected we=1 addr=000100 din=a5",
                         slog[0].we, slog[0].addr, slog[0].din);
            end
            checks++;
            if (slog[0].cyc != c + 2) begin
                errors++;
                $display("FAIL wr_strobe_time: got %0d expected %0d", slog[0].cyc - c, 2);
            end
        end
        checks++;
        if (busy_n != 1) begin
            errors++;
            $display("FAIL ld_busy_len: got %0d expected 1", busy_n);
        end
        checks++;
        if (vlog.size() != 0) begin
            errors++;
            $display("FAIL wr_no_vf_valid: got %0d expected 0", vlog.size());
        end
    endtask

    task automatic test_single_read();
        int c;
        log_clear();
        resp_lat = 3;
        memm[25'h01F000] = 8'h3C;
        @(negedge clk);
        c = cyc;
        vf_req = 1'b1; vf_addr = 25'h01F000;
        @(negedge clk);
        vf_req = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (count_reads() != 1 || slog.size() != 1) begin
            errors++;
            $display("FAIL rd_strobe_count: got %0d expected 1", slog.size());
        end else begin
            checks++;
            if (slog[0].addr !== 25'h01F000 || slog[0].cyc != c + 2) begin
                errors++;
                $display("FAIL rd_cmd: got addr=%h t=%0d expected addr=01f000 t=2", slog[0].addr, slog[0].cyc - c);
            end
        end
        checks++;
        if (vlog.size() != 1) begin
            errors++;
            $display("FAIL rd_valid_count: got %0d expected 1", vlog.size());
        end else begin
            checks++;
            if (vlog[0].data !== 8'h3C || vlog[0].cyc != c + 6) begin
                errors++;
                $display("FAIL rd_data: got %h t=%0d expected 3c t=6", vlog[0].data, vlog[0].cyc - c);
            end
        end
        checks++;
        if (vf_data !== 8'h3C) begin
            errors++;
            $display("FAIL rd_data_hold: got %h expected 3c", vf_data);
        end
    endtask

    task automatic test_simultaneous();
        int c;
        log_clear();
        resp_lat = 2;
        memm[25'h000400] = 8'hC7;
        @(negedge clk);
        c = cyc;
        ld_req = 1'b1; ld_addr = 25'h000300; ld_data = 8'h42;
        vf_req = 1'b1; vf_addr = 25'h000400;
        @(negedge clk);
        ld_req = 1'b0; vf_req = 1'b0;
        repeat (14) @(negedge clk);
        checks++;
        if (slog.size() != 2) begin
            errors++;
            $display("FAIL sim_strobe_count: got %0d expected 2", slog.size());
        end else begin
            checks++;
            if (slog[0].we !== 1'b1 || slog[0].cyc != c + 2 || slog[1].we !== 1'b0 || slog[1].cyc != c + 6) begin
                errors++;
                $display("FAIL sim_order: got we0=%0b t0=%0d we1=%0b t1=%0d expected we0=1 t0=2 we1=0 t1=6",
                         slog[0].we, slog[0].cyc - c, slog[1].we, slog[1].cyc - c);
            end
        end
        checks++;
        if (vlog.size() != 1) begin
            errors++;
            $display("FAIL sim_rd_done: got %0d expected 1", vlog.size());
        end else begin
            checks++;
            if (vlog[0].data !== 8'hC7 || vlog[0].cyc != c + 9) begin
                errors++;
                $display("FAIL sim_rd_data: got %h t=%0d expected c7 t=9", vlog[0].data, vlog[0].cyc - c);
            end
        end
    endtask

    task automatic test_starvation();
        bit         ld_on, second;
        int         nrd;
        logic [9:0] got, exp_pat;
        log_clear();
        resp_lat = 1;
        ld_on    = 1'b1;
        second   = 1'b0;
        exp_pat  = 10'h210;   // W W W W R W W W W R (bit k = strobe k is a read)
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 25'h002000; ld_data = 8'h00;
        vf_req = 1'b1; vf_addr = 25'h001234;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            nrd    = count_reads();
            vf_req = 1'b0;
            if (nrd >= 1 && !second) begin
                vf_req  = 1'b1;
                vf_addr = 25'h001235;
                second  = 1'b1;
            end
            if (nrd >= 2) ld_on = 1'b0;
            ld_req = ld_on && !ld_busy;
            if (ld_req) begin
                ld_addr = 25'(32'h2001 + i);
                ld_data = 8'(i);
            end
        end
        ld_req = 1'b0;
        vf_req = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (slog.size() < 10) begin
            errors++;
            $display("FAIL starve_strobes: got %0d expected >=10", slog.size());
        end else begin
            for (int k = 0; k < 10; k++) got[k] = !slog[k].we;
            checks++;
            if (got !== exp_pat) begin
                errors++;
                $display("FAIL starve_pattern: got %b expected %b", got, exp_pat);
            end
        end
        checks++;
        if (vlog.size() != 2) begin
            errors++;
            $display("FAIL starve_rd_done: got %0d expected 2", vlog.size());
        end
    endtask

    task automatic test_timeout();
        int c;
        log_clear();
        resp_lat = 0;
        @(negedge clk);
        c = cyc;
        vf_req = 1'b1; vf_addr = 25'h000ABC;
        @(negedge clk);
        vf_req = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0 || vlog.size() != 0) begin
            errors++;
            $display("FAIL to_early: got err=%0b valid=%0d expected err=0 valid=0", timeout_err, vlog.size());
        end
        repeat (25) @(negedge clk);
        checks++;
        if (vlog.size() != 1) begin
            errors++;
            $display("FAIL to_valid_count: got %0d expected 1", vlog.size());
        end else begin
            checks++;
            if (vlog[0].data !== 8'hFF || vlog[0].cyc != c + 3 + TIMEOUT) begin
                errors++;
                $display("FAIL to_valid: got %h t=%0d expected ff t=%0d", vlog[0].data, vlog[0].cyc - c, 3 + TIMEOUT);
            end
        end
        checks++;
        if (timeout_err !== 1'b1 || count_reads() != 1) begin
            errors++;
            $display("FAIL to_err: got err=%0b reads=%0d expected err=1 reads=1", timeout_err, count_reads());
        end
        // next request is served normally
        log_clear();
        resp_lat = 1;
        memm[25'h000ABD] = 8'h5E;
        @(negedge clk);
        c = cyc;
        vf_req = 1'b1; vf_addr = 25'h000ABD;
        @(negedge clk);
        vf_req = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (vlog.size() != 1) begin
            errors++;
            $display("FAIL to_recover_count: got %0d expected 1", vlog.size());
        end else begin
            checks++;
            if (vlog[0].data !== 8'h5E || vlog[0].cyc != c + 4) begin
                errors++;
                $display("FAIL to_recover: got %h t=%0d expected 5e t=4", vlog[0].data, vlog[0].cyc - c);
            end
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: got %0b expected 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [46:0] outs;
        int          c;
        log_clear();
        resp_lat = 0;
        @(negedge clk);
        vf_req = 1'b1; vf_addr = 25'h000777;
        @(negedge clk);
        vf_req = 1'b0;
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 25'h000888; ld_data = 8'h99;
        @(negedge clk);
        ld_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        outs = {mem_rd, mem_we, vf_valid, ld_busy, timeout_err, overrun_err, mem_addr, mem_din, vf_data};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_async_outputs: got %h expected 0", outs);
        end
        repeat (2) @(negedge clk);
        reset_n     = 1'b1;
        stray_ready = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (vlog.size() != 0 || slog.size() != 1) begin
            errors++;
            $display("FAIL rst_stray: got valid=%0d strobes=%0d expected valid=0 strobes=1", vlog.size(), slog.size());
        end
        // overrun: second VFD pulse while its slot waits behind the loader
        log_clear();
        resp_lat = 2;
        @(negedge clk);
        c = cyc;
        ld_req = 1'b1; ld_addr = 25'h000999; ld_data = 8'h11;
        vf_req = 1'b1; vf_addr = 25'h000AAA;
        @(negedge clk);
        ld_req = 1'b0;
        vf_req = 1'b1; vf_addr = 25'h000BBB;
        @(negedge clk);
        vf_req = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (overrun_err !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %0b expected 1", overrun_err);
        end
        checks++;
        if (count_reads() != 1 || vlog.size() != 1) begin
            errors++;
            $display("FAIL ovr_single_read: got reads=%0d valid=%0d expected 1/1", count_reads(), vlog.size());
        end else begin
            foreach (slog[k]) if (!slog[k].we) begin
                checks++;
                if (slog[k].addr !== 25'h000AAA) begin
                    errors++;
                    $display("FAIL ovr_rd_addr: got %h expected 000aaa", slog[k].addr);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] wq_addr[$];
        logic [DW-1:0] wq_data[$];
        logic [AW-1:0] rq_addr[$];
        int            rq_cyc[$];
        logic [DW-1:0] refm [logic [AW-1:0]];
        logic [DW-1:0] expd;
        bit            rd_out;
        int wi, ri, nw, nr, bad_wr, bad_ra, bad_rd, bad_st, nwin;

        apply_reset();
        log_clear();
        memm.delete();
        resp_rand = 1'b1;
        rd_out    = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            ld_req = 1'b0;
            vf_req = 1'b0;
            if (vf_valid) rd_out = 1'b0;
            if (i < 760) begin
                if (!ld_busy && $urandom_range(0, 2) == 0) begin
                    ld_req  = 1'b1;
                    ld_addr = 25'($urandom_range(0, 15));
                    ld_data = 8'($urandom);
                    wq_addr.push_back(ld_addr);
                    wq_data.push_back(ld_data);
                end
                if (!rd_out && $urandom_range(0, 3) == 0) begin
                    vf_req  = 1'b1;
                    vf_addr = 25'($urandom_range(0, 15));
                    rd_out  = 1'b1;
                    rq_addr.push_back(vf_addr);
                    rq_cyc.push_back(cyc);
                end
            end
        end
        resp_rand = 1'b0;

        wi = 0; ri = 0; nw = 0; nr = 0;
        bad_wr = 0; bad_ra = 0; bad_rd = 0; bad_st = 0;
        foreach (slog[k]) begin
            if (slog[k].we) begin
                nw++;
                if (wi < wq_addr.size()) begin
                    if (slog[k].addr !== wq_addr[wi] || slog[k].din !== wq_data[wi]) bad_wr++;
                    refm[wq_addr[wi]] = wq_data[wi];
                end
                wi++;
            end else begin
                nr++;
                if (ri < rq_addr.size()) begin
                    if (slog[k].addr !== rq_addr[ri]) bad_ra++;
                    expd = refm.exists(rq_addr[ri]) ? refm[rq_addr[ri]] : (rq_addr[ri][7:0] ^ 8'h5A);
                    if (ri < vlog.size() && vlog[ri].data !== expd) bad_rd++;
                    // loader grants made while this read sat in its slot
                    nwin = 0;
                    foreach (slog[j]) if (slog[j].we && slog[j].cyc >= rq_cyc[ri] + 2 && slog[j].cyc < slog[k].cyc) nwin++;
                    if (nwin > STARVE) bad_st++;
                end
                ri++;
            end
        end
        checks++;
        if (nw != wq_addr.size() || bad_wr != 0) begin
            errors++;
            $display("FAIL rnd_writes: got %0d writes, %0d bad expected %0d writes, 0 bad", nw, bad_wr, wq_addr.size());
        end
        checks++;
        if (nr != rq_addr.size() || bad_ra != 0) begin
            errors++;
            $display("FAIL rnd_reads: got %0d reads, %0d bad addr expected %0d reads, 0 bad", nr, bad_ra, rq_addr.size());
        end
        checks++;
        if (vlog.size() != rq_addr.size() || bad_rd != 0) begin
            errors++;
            $display("FAIL rnd_rd_data: got %0d valid, %0d bad expected %0d valid, 0 bad", vlog.size(), bad_rd, rq_addr.size());
        end
        checks++;
        if (bad_st != 0) begin
            errors++;
            $display("FAIL rnd_starve_bound: got %0d violations expected 0", bad_st);
        end
        checks++;
        if ({timeout_err, overrun_err} !== 2'b00) begin
            errors++;
            $display("FAIL rnd_err_flags: got %b expected 00", {timeout_err, overrun_err});
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ld_req  = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        vf_req  = 1'b0;
        vf_addr = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port between the ROM/asset loader (write requester) and the VFD renderer (read requester). It buffers one request per requester and grants the loader at fixed priority, with a starvation guard for the VFD. It issues one-cycle command strobes to the SDRAM controller and returns read data to the VFD. A watchdog aborts any transfer the controller never completes, so the VFD pipeline cannot stall.

## Interface
- AW, 25, address width (SDRAM byte address)
- DW, 8, data width
- TIMEOUT, 64, cycles in WAIT before a transfer is aborted (≥2)
- STARVE, 4, consecutive loader grants after which a pending VFD read wins

- clk  in  1  system clock (clk_sys domain)
- reset_n  in  1  asynchronous, active-low reset
- ld_req  in  1  one-cycle write request pulse
- ld_addr  in  AW  write address, sampled with ld_req
- ld_data  in  DW  write data, sampled with ld_req
- ld_busy  out  1  loader slot full; loader must not pulse ld_req
- vf_req  in  1  one-cycle read request pulse
- vf_addr  in  AW  read address, sampled with vf_req
- vf_data  out  DW  read data, valid with vf_valid, held until next vf_valid
- vf_valid  out  1  one-cycle read-complete pulse
- mem_addr  out  AW  command address, stable from ISSUE through WAIT
- mem_din  out  DW  write data to controller
- mem_rd  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_dout  in  DW  controller read data, valid with mem_ready
- mem_ready  in  1  controller completion pulse
- timeout_err  out  1  sticky: a transfer was aborted
- overrun_err  out  1  sticky: a request arrived while its slot was full and was dropped

## Operation
- Reset values: all outputs 0. Slots empty, state IDLE, starve counter 0.
- Each requester owns a one-entry slot. A req pulse with the slot empty captures addr/data and sets full. A req pulse with the slot full is dropped and sets overrun_err. ld_busy = loader slot full.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any slot is full, grant and clear that slot (the slot can reload the same cycle), latch the command into the mem_* registers, and go to ISSUE. Otherwise stay in IDLE.
- Grant rule: the loader wins unless the VFD slot is full and the starve count is ≥ STARVE.
  - The starve count increments on each loader grant made while the VFD slot is full.
  - It clears on any VFD grant.
- ISSUE: mem_we (write) or mem_rd (read) is high for exactly this cycle. Go to WAIT. mem_ready is ignored in ISSUE.
- WAIT: the watchdog counts from 0.
  - If mem_ready is sampled high: on a read, register mem_dout into vf_data and pulse vf_valid the next cycle. Go to IDLE.
  - If the count reaches TIMEOUT−1 without mem_ready: set timeout_err and go to IDLE. On a read, set vf_data = all ones and pulse vf_valid, so the VFD never hangs.
- Simultaneous ld_req and vf_req in one cycle: both are captured, and the loader is served first.
- Asserting reset_n low mid-transfer immediately drops the strobes and clears the slots and FSM state. A late mem_ready arriving in IDLE is ignored.

## Timing
- A request sampled at edge N sets its slot at N. The grant is decided in cycle N+1. The strobe is high in cycle N+2.
- Minimum read latency: with mem_ready in the cycle after the strobe (N+3), vf_valid pulses in cycle N+4.
- Back-to-back throughput is one transfer per (controller latency + 2) cycles. IDLE always lasts at least one cycle.
- mem_addr and mem_din are registered and change only on the IDLE→ISSUE transition.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package scramble_pkg holds:
  - the arb_state_t enum (IDLE, ISSUE, WAIT)
  - SDRAM_AW = 25 and SDRAM_DW = 8, used as the defaults for AW/DW
- Sub-module arb_slot holds the one-entry buffer: the full flag, the addr/data registers, overrun detection, and the clear-on-grant-with-reload rule. It is instantiated twice (the VFD instance has no data field).
- The top level contains the grant logic, the FSM, the watchdog and the starve counter.

## Test plan
- Single write: ld_req with addr 0x000100 and data 0xA5 → mem_we high exactly 2 cycles later with mem_addr 0x000100 and mem_din 0xA5. ld_busy stays high for 1 cycle.
- Single read: vf_req with addr 0x1F000 and the model returning 0x3C after 3 cycles → vf_valid is one pulse, vf_data = 0x3C, and mem_rd is never asserted twice.
- Simultaneous ld_req and vf_req → the write strobe precedes the read strobe, and both complete.
- Starvation: the loader keeps its slot refilled continuously while one VFD read is pending → after the loader's 4th grant, the VFD read is granted next and the starve count clears.
- Timeout: the model never asserts mem_ready on a read → vf_valid pulses with vf_data 0xFF after the 64th WAIT cycle, timeout_err = 1, and the next request is served normally.
- Reset mid-WAIT and overrun: assert reset_n low during WAIT → the outputs drop to 0 immediately and a subsequent stray mem_ready produces no vf_valid. After reset, a second vf_req while the slot is full → overrun_err = 1 and only one read is issued.
